// File: rtl/target_pin_arbiter.sv
// Round-robin owner arbiter for the shared target programming / I/O pin group.
// Break-before-make turnaround gaps surround every grant; a hold watchdog revokes stuck owners.
module target_pin_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int TURN_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic                       cfg_enable_i,
    input  logic [15:0]                hold_limit_i,
    input  logic                       timeout_clr_i,
    output logic [NUM_REQ-1:0]         grant_o,
    output logic [$clog2(NUM_REQ)-1:0] owner_o,
    output logic                       busy_o,
    output logic                       timeout_o,
    output logic [1:0]                 dbg_state_o
);

    // Handshake: req_i is a level request held high for the whole time a requester
    // wants the pins; grant_o high means that requester may enable its drivers.
    // Dropping req_i is the release; grant_o falls after the edge that samples it low.

    localparam int OW = $clog2(NUM_REQ);
    localparam logic [3:0] TURN_LOAD = 4'(TURN_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_TURN_ON = 2'd1,
        S_GRANTED = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t             state;
    logic [3:0]         turn_cnt;
    logic [15:0]        hold_cnt;
    logic [NUM_REQ-1:0] mask;
    logic [OW-1:0]      owner;
    logic [OW-1:0]      last_owner;

    logic [NUM_REQ-1:0] eligible;
    logic               win_found;
    logic [OW-1:0]      win_idx;
    logic               owner_req;
    logic               wd_hit;
    logic               grant_release;
    logic [NUM_REQ-1:0] owner_onehot;
    logic [NUM_REQ-1:0] mask_next;

    assign eligible     = req_i & ~mask;
    assign owner_req    = req_i[owner];
    assign owner_onehot = NUM_REQ'(1) << owner;

    // Search downward in distance so the closest index after last_owner is written last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (eligible[OW'((int'(last_owner) + k) % NUM_REQ)]) begin
                win_found = 1'b1;
                win_idx   = OW'((int'(last_owner) + k) % NUM_REQ);
            end
        end
    end

    // Compared live against the limit, so a lowered limit bites on the very next edge.
    assign wd_hit = (state == S_GRANTED) && (hold_limit_i != 16'd0) &&
                    ((17'(hold_cnt) + 17'd1) >= 17'(hold_limit_i));

    assign grant_release = !owner_req || !cfg_enable_i || wd_hit;

    always_comb begin
        mask_next = mask & req_i;
        if (wd_hit) begin
            mask_next[owner] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            turn_cnt   <= '0;
            hold_cnt   <= '0;
            mask       <= '0;
            owner      <= '0;
            last_owner <= OW'(NUM_REQ - 1);
            grant_o    <= '0;
            timeout_o  <= 1'b0;
        end else begin
            mask <= mask_next;

            if (wd_hit) begin
                timeout_o <= 1'b1;
            end else if (timeout_clr_i) begin
                timeout_o <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (cfg_enable_i && win_found) begin
                        owner      <= win_idx;
                        last_owner <= win_idx;
                        turn_cnt   <= TURN_LOAD;
                        state      <= S_TURN_ON;
                    end
                end
                S_TURN_ON: begin
                    if (!owner_req || !cfg_enable_i) begin
                        turn_cnt <= TURN_LOAD;
                        state    <= S_RELEASE;
                    end else if (turn_cnt == 4'd0) begin
                        hold_cnt <= '0;
                        grant_o  <= owner_onehot;
                        state    <= S_GRANTED;
                    end else begin
                        turn_cnt <= turn_cnt - 4'd1;
                    end
                end
                S_GRANTED: begin
                    if (hold_cnt != 16'hFFFF) begin
                        hold_cnt <= hold_cnt + 16'd1;
                    end
                    if (grant_release) begin
                        grant_o  <= '0;
                        turn_cnt <= TURN_LOAD;
                        state    <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (turn_cnt == 4'd0) begin
                        state <= S_IDLE;
                    end else begin
                        turn_cnt <= turn_cnt - 4'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign owner_o     = owner;
    assign busy_o      = (state != S_IDLE);
    assign dbg_state_o = state;

endmodule

// File: tb/tb_target_pin_arbiter.sv
// Bench for target_pin_arbiter: table-driven single-grant vectors plus hand sequences
// for watchdog, disable, async reset and round-robin rotation, with a grant-order scoreboard.
module tb_target_pin_arbiter;

    localparam int NUM_REQ = 4;
    localparam int TC      = 2;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [NUM_REQ-1:0] req;
    logic               en;
    logic [15:0]        hl;
    logic               clr;
    logic [NUM_REQ-1:0] grant;
    logic [1:0]         owner;
    logic               busy;
    logic               timeout;
    logic [1:0]         dbg_state;

    int checks = 0;
    int errors = 0;

    logic [NUM_REQ-1:0] exp_q[$];

    typedef struct {
        logic [3:0]  req;
        logic [15:0] hl;
        int          hold;
        logic [3:0]  exp_grant;
        logic [1:0]  exp_owner;
        int          exp_dur;
        logic        exp_to;
    } vec_t;

    vec_t vecs[12];

    target_pin_arbiter #(.NUM_REQ(NUM_REQ), .TURN_CYCLES(TC)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_i        (req),
        .cfg_enable_i (en),
        .hold_limit_i (hl),
        .timeout_clr_i(clr),
        .grant_o      (grant),
        .owner_o      (owner),
        .busy_o       (busy),
        .timeout_o    (timeout),
        .dbg_state_o  (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=expired expected=event", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(output int lat);
        lat = 0;
        while (grant == '0 && lat < 40) begin
            tick();
            lat++;
        end
        if (grant == '0) fail_now("grant_wait");
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        if (busy) fail_now("idle_wait");
    endtask

    // Grant monitor: scoreboard pop on each rising grant, one-hot and gap checks.
    logic [NUM_REQ-1:0] prev_grant = '0;
    int                 gap = 0;
    bit                 gap_valid = 1'b0;

    always @(posedge clk) begin
        logic [NUM_REQ-1:0] e;
        #2;
        if (!reset_n) begin
            prev_grant = '0;
            gap_valid  = 1'b0;
            gap        = 0;
        end else begin
            check("onehot", 32'($countones(grant) <= 1), 32'd1);
            if (grant != '0 && prev_grant == '0) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_grant");
                end else begin
                    e = exp_q.pop_front();
                    check("grant_order", 32'(grant), 32'(e));
                end
                if (gap_valid) check("gap_min", 32'(gap >= 2 * TC + 1), 32'd1);
            end
            if (grant == '0 && prev_grant != '0) begin
                gap       = 1;
                gap_valid = 1'b1;
            end else if (grant == '0) begin
                gap++;
            end
            prev_grant = grant;
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int lat;
        int l2;
        int dur;
        bit seen;

        vecs[0]  = '{4'b0001, 16'd0,     5,  4'b0001, 2'd0, 5, 1'b0};
        vecs[1]  = '{4'b0100, 16'd0,     3,  4'b0100, 2'd2, 3, 1'b0};
        vecs[2]  = '{4'b1000, 16'd0,     1,  4'b1000, 2'd3, 1, 1'b0};
        vecs[3]  = '{4'b0100, 16'd8,     20, 4'b0100, 2'd2, 8, 1'b1};
        vecs[4]  = '{4'b0010, 16'd3,     10, 4'b0010, 2'd1, 3, 1'b1};
        vecs[5]  = '{4'b0001, 16'hFFFF,  4,  4'b0001, 2'd0, 4, 1'b0};
        vecs[6]  = '{4'b0010, 16'd1,     6,  4'b0010, 2'd1, 1, 1'b1};
        vecs[7]  = '{4'b1010, 16'd0,     2,  4'b1000, 2'd3, 2, 1'b0};
        vecs[8]  = '{4'b0011, 16'd0,     3,  4'b0001, 2'd0, 3, 1'b0};
        vecs[9]  = '{4'b0110, 16'd0,     2,  4'b0010, 2'd1, 2, 1'b0};
        vecs[10] = '{4'b0101, 16'd0,     2,  4'b0100, 2'd2, 2, 1'b0};
        vecs[11] = '{4'b1001, 16'd0,     2,  4'b1000, 2'd3, 2, 1'b0};

        reset_n = 1'b0;
        req     = '0;
        en      = 1'b1;
        hl      = 16'd0;
        clr     = 1'b0;
        repeat (3) tick();
        check("rst_grant",   32'(grant),     32'd0);
        check("rst_owner",   32'(owner),     32'd0);
        check("rst_busy",    32'(busy),      32'd0);
        check("rst_timeout", 32'(timeout),   32'd0);
        check("rst_state",   32'(dbg_state), 32'd0);
        reset_n = 1'b1;
        tick();

        foreach (vecs[i]) begin
            hl  = vecs[i].hl;
            req = vecs[i].req;
            exp_q.push_back(vecs[i].exp_grant);
            tick();
            check("turn_on_busy", 32'(busy), 32'd1);
            check("turn_on_grant_low", 32'(grant), 32'd0);
            wait_grant(l2);
            lat = 1 + l2;
            check("grant_latency", 32'(lat), 32'(TC + 1));
            check("owner", 32'(owner), 32'(vecs[i].exp_owner));
            dur = 0;
            for (int s = 0; s < vecs[i].hold; s++) begin
                if (grant != '0) dur++;
                if (s == vecs[i].hold - 1) req = '0;
                tick();
            end
            check("grant_duration", 32'(dur), 32'(vecs[i].exp_dur));
            check("grant_released", 32'(grant), 32'd0);
            check("timeout_flag", 32'(timeout), 32'(vecs[i].exp_to));
            if (!vecs[i].exp_to) begin
                check("release_busy", 32'(busy), 32'd1);
                tick();
                tick();
                check("idle_after_turn", 32'(busy), 32'd0);
            end else begin
                wait_idle();
                clr = 1'b1;
                tick();
                clr = 1'b0;
                check("timeout_clear", 32'(timeout), 32'd0);
            end
        end

        // Watchdog revoke coinciding with a clear pulse, then mask and re-grant.
        hl  = 16'd8;
        req = 4'b0100;
        exp_q.push_back(4'b0100);
        wait_grant(lat);
        dur = 0;
        for (int s = 0; s < 8; s++) begin
            if (grant != '0) dur++;
            if (s == 7) clr = 1'b1;
            tick();
        end
        clr = 1'b0;
        check("wd_duration", 32'(dur), 32'd8);
        check("wd_revoked", 32'(grant), 32'd0);
        check("set_beats_clear", 32'(timeout), 32'd1);
        repeat (6) tick();
        check("no_regrant_masked", 32'(grant), 32'd0);
        check("masked_idle", 32'(busy), 32'd0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("later_clear", 32'(timeout), 32'd0);
        req = '0;
        tick();
        req = 4'b0100;
        exp_q.push_back(4'b0100);
        wait_grant(lat);
        check("regrant_after_drop", 32'(owner), 32'd2);
        hl  = 16'd0;
        req = '0;
        wait_idle();

        // Disable mid-grant.
        req = 4'b0010;
        exp_q.push_back(4'b0010);
        wait_grant(lat);
        tick();
        tick();
        en = 1'b0;
        tick();
        check("disable_release", 32'(grant), 32'd0);
        check("disable_busy", 32'(busy), 32'd1);
        seen = 1'b0;
        repeat (10) begin
            tick();
            if (grant != '0) seen = 1'b1;
        end
        check("no_grant_disabled", 32'(seen), 32'd0);
        check("disabled_idle", 32'(busy), 32'd0);
        exp_q.push_back(4'b0010);
        en = 1'b1;
        wait_grant(lat);
        check("reenable_owner", 32'(owner), 32'd1);
        req = '0;
        wait_idle();

        // Async reset mid-TURN_ON.
        req = 4'b0100;
        tick();
        check("turn_on_state", 32'(dbg_state), 32'd1);
        #3 reset_n = 1'b0;
        #1;
        check("arst_turn_busy",  32'(busy),      32'd0);
        check("arst_turn_owner", 32'(owner),     32'd0);
        check("arst_turn_state", 32'(dbg_state), 32'd0);
        req = '0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Async reset mid-GRANTED.
        req = 4'b1000;
        exp_q.push_back(4'b1000);
        wait_grant(lat);
        check("pre_arst_owner", 32'(owner), 32'd3);
        #3 reset_n = 1'b0;
        #1;
        check("arst_grant", 32'(grant), 32'd0);
        check("arst_owner", 32'(owner), 32'd0);
        check("arst_busy",  32'(busy),  32'd0);
        req = '0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Round-robin rotation with all requesters active.
        req = 4'b1111;
        for (int i = 0; i < 5; i++) exp_q.push_back(NUM_REQ'(1) << (i % NUM_REQ));
        for (int i = 0; i < 5; i++) begin
            wait_grant(lat);
            check("rr_owner", 32'(owner), 32'(i % NUM_REQ));
            for (int s = 0; s < 5; s++) begin
                if (s == 4) req[owner] = 1'b0;
                tick();
            end
            check("rr_release", 32'(grant), 32'd0);
            req = (i == 4) ? 4'b0000 : 4'b1111;
        end
        wait_idle();
        repeat (3) tick();

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
